// File: rtl/sorted_insert.sv
// sorted_insert: inserts a value into an external 32x8 memory kept in non-decreasing order
module sorted_insert #(
   parameter int DEPTH = 32
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [7:0] A,
   input  logic [7:0] Data,
   output logic [7:0] Addr,
   output logic [7:0] WrData,
   output logic       wren,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [5:0] Count
);
   typedef enum logic [2:0] {IDLE, RD, CMP, SHIFT, PUT, DONE} state_t;
   state_t state, nxt;
   logic [5:0] i, im1;
   logic [7:0] a_q, d_q, addr_q, wdata_q;
   logic full;
   assign full = Count == 6'(DEPTH);
   assign im1 = i - 6'd1;
   assign busy = state != IDLE;
   assign done = state == DONE;
   // Addr/WrData fall back to their last driven values outside the memory-access states
   always_comb begin
      nxt = state;
      Addr = addr_q;
      WrData = wdata_q;
      wren = 1'b0;
      case (state)
         IDLE: if (start && !full) nxt = (Count == 6'd0) ? PUT : RD;
         RD: begin
            Addr = 8'(im1);
            nxt = CMP;
         end
         CMP: nxt = (Data > a_q) ? SHIFT : PUT;
         SHIFT: begin
            Addr = 8'(i);
            WrData = d_q;
            wren = 1'b1;
            nxt = (im1 == 6'd0) ? PUT : RD;
         end
         PUT: begin
            Addr = 8'(i);
            WrData = a_q;
            wren = 1'b1;
            nxt = DONE;
         end
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         i <= '0;
         a_q <= '0;
         d_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         err <= 1'b0;
         Count <= '0;
      end else begin
         state <= nxt;
         addr_q <= Addr;
         wdata_q <= WrData;
         err <= state == IDLE && start && full;
         if (state == IDLE && start && !full) begin
            a_q <= A;
            i <= Count;
         end
         if (state == CMP) d_q <= Data;
         if (state == SHIFT) i <= im1;
         if (state == PUT && !full) Count <= Count + 6'd1;
      end
   end
endmodule

// File: tb/tb_sorted_insert.sv
// tb_sorted_insert: directed checks of sorted_insert against a behavioural 32x8 synchronous memory
module tb_sorted_insert;
   logic clk = 1'b0, clr = 1'b0, start = 1'b0;
   logic [7:0] A = '0, data;
   logic [7:0] Addr, WrData;
   logic wren, busy, done, err;
   logic [5:0] Count;
   logic [7:0] mem [32];
   logic [7:0] refm [32];
   int errors = 0, checks = 0, wr_cnt = 0, hi_addr = 0, n = 0;

   sorted_insert #(.DEPTH(32)) dut (
      .clk(clk), .clr(clr), .start(start), .A(A), .Data(data),
      .Addr(Addr), .WrData(WrData), .wren(wren), .busy(busy),
      .done(done), .err(err), .Count(Count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wren) begin
         mem[Addr[4:0]] <= WrData;
         wr_cnt <= wr_cnt + 1;
      end
      data <= mem[Addr[4:0]];
   end

   always @(negedge clk) if (Addr[7:5] != 3'd0) hi_addr <= hi_addr + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // cycle 0 is the start cycle; returns the cycle in which done is seen (200 on timeout)
   task automatic do_insert(input logic [7:0] v, output int cyc);
      @(negedge clk);
      start = 1'b1;
      A = v;
      @(negedge clk);
      start = 1'b0;
      A = ~v;
      cyc = 1;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
   endtask

   // reference insertion: equal values stay below the new one
   task automatic model_insert(input logic [7:0] v);
      int k, c, expc;
      k = 0;
      for (int j = 0; j < n; j++) if (refm[j] > v) k++;
      expc = (k < n) ? 3 * k + 4 : 3 * n + 2;
      do_insert(v, c);
      chk($sformatf("rand_lat_%0d", n), c, expc);
      for (int j = n; j > n - k; j--) refm[j] = refm[j-1];
      refm[n-k] = v;
      n++;
   endtask

   initial begin
      int c, w0;
      #1;
      chk("rst_count", Count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wren", wren, 0);
      chk("rst_addr", Addr, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      clr = 1'b1;

      do_insert(8'h40, c);
      chk("empty_lat", c, 2);
      chk("empty_mem0", mem[0], 8'h40);
      chk("empty_count", Count, 1);

      reset_dut();
      do_insert(8'h10, c);
      do_insert(8'h20, c);
      chk("append_lat", c, 4);
      do_insert(8'h30, c);
      do_insert(8'h05, c);
      chk("full_shift_lat", c, 11);
      chk("fs_mem0", mem[0], 8'h05);
      chk("fs_mem1", mem[1], 8'h10);
      chk("fs_mem2", mem[2], 8'h20);
      chk("fs_mem3", mem[3], 8'h30);
      chk("fs_count", Count, 4);

      reset_dut();
      do_insert(8'h10, c);
      do_insert(8'h20, c);
      do_insert(8'h30, c);
      do_insert(8'h25, c);
      chk("mid_lat", c, 7);
      chk("mid_mem0", mem[0], 8'h10);
      chk("mid_mem1", mem[1], 8'h20);
      chk("mid_mem2", mem[2], 8'h25);
      chk("mid_mem3", mem[3], 8'h30);

      reset_dut();
      do_insert(8'h10, c);
      do_insert(8'h20, c);
      do_insert(8'h20, c);
      chk("equal_lat", c, 4);
      chk("equal_mem1", mem[1], 8'h20);
      chk("equal_mem2", mem[2], 8'h20);
      chk("equal_count", Count, 3);

      reset_dut();
      n = 0;
      for (int r = 0; r < 32; r++) model_insert(8'($urandom_range(0, 255)));
      chk("rand_count", Count, 32);
      for (int j = 0; j < 32; j++) chk($sformatf("rand_mem%0d", j), mem[j], refm[j]);

      w0 = wr_cnt;
      @(negedge clk);
      start = 1'b1;
      A = 8'h00;
      @(negedge clk);
      start = 1'b0;
      chk("full_err_pulse", err, 1);
      chk("full_busy", busy, 0);
      @(negedge clk);
      chk("full_err_end", err, 0);
      @(negedge clk);
      chk("full_err_once", err, 0);
      chk("full_no_write", wr_cnt, w0);
      chk("full_count", Count, 32);

      reset_dut();
      do_insert(8'h50, c);
      do_insert(8'h60, c);
      @(negedge clk);
      start = 1'b1;
      A = 8'h01;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (!wren && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("shift_reached", c, 3);
      #1 clr = 1'b0;
      #1;
      chk("abort_wren", wren, 0);
      chk("abort_count", Count, 0);
      chk("abort_busy", busy, 0);
      w0 = wr_cnt;
      @(negedge clk);
      clr = 1'b1;
      chk("abort_no_write", wr_cnt, w0);
      do_insert(8'h77, c);
      chk("after_abort_lat", c, 2);
      chk("after_abort_mem0", mem[0], 8'h77);
      chk("after_abort_count", Count, 1);
      chk("addr_high_bits", hi_addr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
